// File: rtl/mct_pkg.sv
//------------------------------------------------------------------------------
// Module   : mct_pkg
// Brief    : Shared constants for the multi-channel interval timer: register
//            offsets, CONTROL bit positions and STATUS bit positions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mct_pkg;

   // Per-channel register offsets (low three bits of the word address)
   localparam logic [2:0] OFS_STATUS   = 3'd0;
   localparam logic [2:0] OFS_CONTROL  = 3'd1;
   localparam logic [2:0] OFS_PERIOD_L = 3'd2;
   localparam logic [2:0] OFS_PERIOD_H = 3'd3;
   localparam logic [2:0] OFS_SNAP_L   = 3'd4;
   localparam logic [2:0] OFS_SNAP_H   = 3'd5;
   localparam logic [2:0] OFS_PRESCALE = 3'd6;

   // CONTROL bit positions
   localparam int CTL_ITO   = 0;
   localparam int CTL_CONT  = 1;
   localparam int CTL_START = 2;
   localparam int CTL_STOP  = 3;

   // STATUS bit positions
   localparam int ST_TO  = 0;
   localparam int ST_RUN = 1;

endpackage

`default_nettype wire

// File: rtl/mct_channel.sv
//------------------------------------------------------------------------------
// Module   : mct_channel
// Brief    : One timer channel: down-counter, prescaler, RUN/TO flags, period,
//            snapshot, control and prescale registers, plus its read word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mct_channel
   import mct_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int PERIOD_RST = 49999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr,
   input  logic [2:0]  offset,
   input  logic [15:0] writedata,
   output logic [15:0] rdata,
   output logic        irq
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_snap;
   logic [3:0]       r_control;
   logic [15:0]      r_prescale;
   logic [15:0]      r_pcount;
   logic             r_run;
   logic             r_to;

   logic [CNT_W-1:0] w_period_nxt;
   logic             w_tick;
   logic             w_timeout;

   assign w_tick    = r_run && (r_pcount == r_prescale);
   assign w_timeout = w_tick && (r_count == '0);

   // Merge a PERIOD_L/H write into the current period; bits above CNT_W drop
   always_comb begin
      w_period_nxt = r_period;
      if (offset == OFS_PERIOD_H)
         w_period_nxt[CNT_W-1:16] = writedata[CNT_W-17:0];
      else
         w_period_nxt[15:0] = writedata;
   end

   // Counting first, then bus writes, so later assignments take priority
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count    <= CNT_W'(PERIOD_RST);
         r_period   <= CNT_W'(PERIOD_RST);
         r_snap     <= '0;
         r_control  <= '0;
         r_prescale <= '0;
         r_pcount   <= '0;
         r_run      <= 1'b0;
         r_to       <= 1'b0;
      end else begin
         if (r_run)
            r_pcount <= w_tick ? '0 : r_pcount + 16'd1;
         if (w_tick) begin
            if (w_timeout) begin
               r_count <= r_period;
               r_to    <= 1'b1;
               if (!r_control[CTL_CONT])
                  r_run <= 1'b0;
            end else begin
               r_count <= r_count - CNT_W'(1);
            end
         end
         if (wr) begin
            case (offset)
               // A timeout in the same cycle must not be lost
               OFS_STATUS: if (!w_timeout) r_to <= 1'b0;
               OFS_CONTROL: begin
                  r_control <= writedata[3:0];
                  if (writedata[CTL_START]) begin
                     r_run    <= 1'b1;
                     r_pcount <= '0;
                  end else if (writedata[CTL_STOP]) begin
                     r_run <= 1'b0;
                  end
               end
               // New period also wins over a same-cycle timeout reload
               OFS_PERIOD_L, OFS_PERIOD_H: begin
                  r_period <= w_period_nxt;
                  r_count  <= w_period_nxt;
                  r_run    <= 1'b0;
               end
               OFS_SNAP_L, OFS_SNAP_H: r_snap <= r_count;
               OFS_PRESCALE: begin
                  r_prescale <= writedata;
                  r_pcount   <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   // Read word selection for this channel
   always_comb begin
      rdata = '0;
      case (offset)
         OFS_STATUS: begin
            rdata[ST_RUN] = r_run;
            rdata[ST_TO]  = r_to;
         end
         OFS_CONTROL:  rdata[3:0] = r_control;
         OFS_PERIOD_L: rdata = r_period[15:0];
         OFS_PERIOD_H: rdata = 16'(r_period >> 16);
         OFS_SNAP_L:   rdata = r_snap[15:0];
         OFS_SNAP_H:   rdata = 16'(r_snap >> 16);
         OFS_PRESCALE: rdata = r_prescale;
         default:      rdata = '0;
      endcase
   end

   assign irq = r_to & r_control[CTL_ITO];

endmodule

`default_nettype wire

// File: rtl/multi_channel_interval_timer.sv
//------------------------------------------------------------------------------
// Module   : multi_channel_interval_timer
// Brief    : N-channel Avalon-MM interval timer. Decodes the channel field of
//            the word address, registers the read word, ORs channel interrupts.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_channel_interval_timer
   import mct_pkg::*;
#(
   parameter  int N_CH       = 4,
   parameter  int CNT_W      = 32,
   parameter  int PERIOD_RST = 49999,
   localparam int AW         = 3 + $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [AW-1:0]   address,
   input  logic            chipselect,
   input  logic            write_n,
   input  logic [15:0]     writedata,
   output logic [15:0]     readdata,
   output logic            irq,
   output logic [N_CH-1:0] irq_vec
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [CH_W-1:0] w_ch;
   logic            w_wr;
   logic [15:0]     w_rdata [N_CH];
   logic [15:0]     w_rd_mux;

   assign w_wr = chipselect & ~write_n;

   generate
      if (N_CH > 1) begin : g_ch_dec
         assign w_ch = address[AW-1:3];
      end else begin : g_ch_single
         assign w_ch = '0;
      end
   endgenerate

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         mct_channel #(
            .CNT_W      (CNT_W),
            .PERIOD_RST (PERIOD_RST)
         ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr        (w_wr && (w_ch == CH_W'(i))),
            .offset    (address[2:0]),
            .writedata (writedata),
            .rdata     (w_rdata[i]),
            .irq       (irq_vec[i])
         );
      end
   endgenerate

   // Channel read mux; unpopulated channel indices read as zero
   always_comb begin
      w_rd_mux = '0;
      for (int i = 0; i < N_CH; i++)
         if (w_ch == CH_W'(i))
            w_rd_mux = w_rdata[i];
   end

   // Read word registered every clock, independent of chipselect
   always_ff @(posedge clk) begin
      if (!reset_n)
         readdata <= '0;
      else
         readdata <= w_rd_mux;
   end

   assign irq = |irq_vec;

endmodule

`default_nettype wire
